// File: rtl/riscv_mc_pkg.sv
// Shared types and encodings for the multicycle RV32I control unit.
package riscv_mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_JAL      = 4'd9,
        S_BRANCH   = 4'd10
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_SLL = 3'b110;
    localparam logic [2:0] ALU_SRL = 3'b111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath bundle: IR/flags toward the controller, control strobes back.
interface multicycle_controller_if #(
    parameter int ALUCTRL_W = 3,
    parameter int STATE_W   = 4
);
    logic [31:0]          Instr;
    logic                 Zero;
    logic                 MemReady;
    logic                 PCWrite;
    logic                 AdrSrc;
    logic                 MemWrite;
    logic                 IRWrite;
    logic [1:0]           ResultSrc;
    logic [1:0]           ALUSrcA;
    logic [1:0]           ALUSrcB;
    logic [1:0]           ImmSrc;
    logic [ALUCTRL_W-1:0] ALUControl;
    logic                 RegWrite;
    logic                 IllegalInstr;
    logic [STATE_W-1:0]   State;

    modport master (
        input  Instr, Zero, MemReady,
        output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
               ImmSrc, ALUControl, RegWrite, IllegalInstr, State
    );

    modport slave (
        output Instr, Zero, MemReady,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
               ImmSrc, ALUControl, RegWrite, IllegalInstr, State
    );
endinterface

// File: rtl/alu_decoder.sv
// Maps ALUOp plus instruction function fields to a 3-bit ALU operation code.
module alu_decoder
    import riscv_mc_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       op5,
    input  logic       funct7b5,
    output logic [2:0] alu_control
);
    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // Only R-type subtracts; addi ignores bit 30
                    3'b000:  alu_control = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b001:  alu_control = ALU_SLL;
                    3'b101:  alu_control = ALU_SRL;
                    3'b111:  alu_control = ALU_AND;
                    3'b110:  alu_control = ALU_OR;
                    3'b100:  alu_control = ALU_XOR;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end
endmodule

// File: rtl/multicycle_controller.sv
// Moore main FSM for the multicycle RV32I core; sequences each instruction over 3-5 cycles.
module multicycle_controller
    import riscv_mc_pkg::*;
#(
    parameter int ALUCTRL_W     = 3,
    parameter bit USE_MEM_READY = 1'b1,
    parameter int STATE_W       = 4
) (
    input logic                     clk,
    input logic                     reset,
    multicycle_controller_if.master bus
);
    state_t     state, state_next;
    logic       rdy;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic [1:0] alu_op;
    logic [2:0] alu_code;
    logic       pc_write, ir_write, reg_write, mem_write, illegal;
    logic       unused_instr;

    assign op           = bus.Instr[6:0];
    assign funct3       = bus.Instr[14:12];
    assign funct7b5     = bus.Instr[30];
    assign unused_instr = ^{bus.Instr[31], bus.Instr[29:15], bus.Instr[11:7]};
    assign rdy          = USE_MEM_READY ? bus.MemReady : 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_FETCH;
        else       state <= state_next;
    end

    always_comb begin
        state_next    = state;
        pc_write      = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        mem_write     = 1'b0;
        illegal       = 1'b0;
        alu_op        = ALUOP_ADD;
        bus.AdrSrc    = 1'b0;
        bus.ResultSrc = RES_ALUOUT;
        bus.ALUSrcA   = SRCA_PC;
        bus.ALUSrcB   = SRCB_RD2;
        case (state)
            S_FETCH: begin
                bus.ALUSrcB   = SRCB_FOUR;
                bus.ResultSrc = RES_ALURESULT;
                ir_write      = rdy;
                pc_write      = rdy;
                if (rdy) state_next = S_DECODE;
            end
            S_DECODE: begin
                bus.ALUSrcA = SRCA_OLDPC;
                bus.ALUSrcB = SRCB_IMM;
                case (op)
                    OP_LOAD, OP_STORE: state_next = S_MEMADR;
                    OP_RTYPE:          state_next = S_EXECUTER;
                    OP_ITYPE:          state_next = S_EXECUTEI;
                    OP_JAL:            state_next = S_JAL;
                    OP_BRANCH:         state_next = S_BRANCH;
                    default: begin
                        state_next = S_FETCH;
                        illegal    = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                bus.ALUSrcA = SRCA_RD1;
                bus.ALUSrcB = SRCB_IMM;
                state_next  = op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                bus.AdrSrc = 1'b1;
                if (rdy) state_next = S_MEMWB;
            end
            S_MEMWB: begin
                bus.ResultSrc = RES_DATA;
                reg_write     = 1'b1;
                state_next    = S_FETCH;
            end
            S_MEMWRITE: begin
                // Strobe held for the whole access, including the completing cycle
                bus.AdrSrc = 1'b1;
                mem_write  = 1'b1;
                if (rdy) state_next = S_FETCH;
            end
            S_EXECUTER: begin
                bus.ALUSrcA = SRCA_RD1;
                alu_op      = ALUOP_FUNCT;
                state_next  = S_ALUWB;
            end
            S_EXECUTEI: begin
                bus.ALUSrcA = SRCA_RD1;
                bus.ALUSrcB = SRCB_IMM;
                alu_op      = ALUOP_FUNCT;
                state_next  = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write  = 1'b1;
                state_next = S_FETCH;
            end
            S_JAL: begin
                bus.ALUSrcA = SRCA_OLDPC;
                bus.ALUSrcB = SRCB_FOUR;
                pc_write    = 1'b1;
                state_next  = S_ALUWB;
            end
            S_BRANCH: begin
                bus.ALUSrcA = SRCA_RD1;
                alu_op      = ALUOP_SUB;
                // beq taken on Zero, bne taken on !Zero
                pc_write    = bus.Zero ^ funct3[0];
                state_next  = S_FETCH;
            end
            default: state_next = S_FETCH;
        endcase
    end

    always_comb begin
        case (op)
            OP_STORE:  bus.ImmSrc = IMM_S;
            OP_BRANCH: bus.ImmSrc = IMM_B;
            OP_JAL:    bus.ImmSrc = IMM_J;
            default:   bus.ImmSrc = IMM_I;
        endcase
    end

    alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct3      (funct3),
        .op5         (op[5]),
        .funct7b5    (funct7b5),
        .alu_control (alu_code)
    );

    // Strobes are forced low while reset is held, even though FETCH would assert them
    assign bus.PCWrite      = pc_write  & ~reset;
    assign bus.IRWrite      = ir_write  & ~reset;
    assign bus.RegWrite     = reg_write & ~reset;
    assign bus.MemWrite     = mem_write & ~reset;
    assign bus.IllegalInstr = illegal   & ~reset;
    assign bus.ALUControl   = ALUCTRL_W'(alu_code);
    assign bus.State        = STATE_W'(state);
endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench: per-instruction expected cycle traces built from instruction class and stall pattern.
module tb_multicycle_controller;
    localparam logic [6:0] T_LW = 7'b0000011, T_SW = 7'b0100011, T_R = 7'b0110011;
    localparam logic [6:0] T_I = 7'b0010011, T_JAL = 7'b1101111, T_BR = 7'b1100011;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw, adr, memw, irw;
        logic [1:0] rs, sa, sb, imm;
        logic [2:0] alu;
        logic       regw, ill;
    } obs_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    obs_t q1[$];
    obs_t q2[$];
    logic rq[$];

    always #5 clk = ~clk;

    multicycle_controller_if #(.ALUCTRL_W(3), .STATE_W(4)) b1 ();
    multicycle_controller_if #(.ALUCTRL_W(5), .STATE_W(6)) b2 ();

    multicycle_controller #(.ALUCTRL_W(3), .USE_MEM_READY(1'b1), .STATE_W(4)) dut1 (
        .clk(clk), .reset(reset), .bus(b1));
    multicycle_controller #(.ALUCTRL_W(5), .USE_MEM_READY(1'b0), .STATE_W(6)) dut2 (
        .clk(clk), .reset(reset), .bus(b2));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic obs_t sample1();
        obs_t a;
        a = {b1.State[3:0], b1.PCWrite, b1.AdrSrc, b1.MemWrite, b1.IRWrite, b1.ResultSrc,
             b1.ALUSrcA, b1.ALUSrcB, b1.ImmSrc, b1.ALUControl, b1.RegWrite, b1.IllegalInstr};
        return a;
    endfunction

    function automatic obs_t sample2();
        obs_t a;
        a = {b2.State[3:0], b2.PCWrite, b2.AdrSrc, b2.MemWrite, b2.IRWrite, b2.ResultSrc,
             b2.ALUSrcA, b2.ALUSrcB, b2.ImmSrc, b2.ALUControl[2:0], b2.RegWrite, b2.IllegalInstr};
        return a;
    endfunction

    always @(negedge clk) begin
        if (q1.size() > 0) begin
            obs_t e;
            e = q1.pop_front();
            chk("dut1_cycle", 32'(sample1()), 32'(e));
        end
    end

    always @(negedge clk) begin
        if (q2.size() > 0) begin
            obs_t e;
            e = q2.pop_front();
            chk("dut2_cycle", 32'(sample2()), 32'(e));
            chk("dut2_zero_ext", {28'd0, b2.ALUControl[4:3], b2.State[5:4]}, 32'd0);
        end
    end

    function automatic logic [2:0] alu_exp(input logic [2:0] f3, input bit is_r, input logic f7);
        case (f3)
            3'b000:  return (is_r && f7) ? 3'd1 : 3'd0;
            3'b010:  return 3'd5;
            3'b001:  return 3'd6;
            3'b101:  return 3'd7;
            3'b111:  return 3'd2;
            3'b110:  return 3'd3;
            3'b100:  return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

    function automatic obs_t blank(input int st, input logic [1:0] imm);
        obs_t o;
        o     = '0;
        o.st  = 4'(st);
        o.imm = imm;
        return o;
    endfunction

    task automatic emit(input int d, input obs_t o, input logic r);
        if (d == 1) q1.push_back(o);
        else        q2.push_back(o);
        rq.push_back((d == 1) ? r : 1'b0);
    endtask

    // Build the whole expected trace for one instruction, then drive it cycle by cycle.
    task automatic run(input int d, input logic [31:0] ins, input logic z, input int fs, input int ms);
        logic [6:0] op;
        logic [2:0] f3;
        logic [1:0] imm;
        obs_t       o;
        op  = ins[6:0];
        f3  = ins[14:12];
        imm = (op == T_SW) ? 2'd1 : (op == T_BR) ? 2'd2 : (op == T_JAL) ? 2'd3 : 2'd0;
        for (int i = 0; i < fs; i++) begin
            o = blank(0, imm); o.sb = 2; o.rs = 2; emit(d, o, 1'b0);
        end
        o = blank(0, imm); o.sb = 2; o.rs = 2; o.irw = 1; o.pcw = 1; emit(d, o, 1'b1);
        o = blank(1, imm); o.sa = 1; o.sb = 1;
        o.ill = !(op inside {T_LW, T_SW, T_R, T_I, T_JAL, T_BR});
        emit(d, o, 1'($urandom_range(0, 1)));
        if (op == T_LW || op == T_SW) begin
            o = blank(2, imm); o.sa = 2; o.sb = 1; emit(d, o, 1'($urandom_range(0, 1)));
            for (int i = 0; i <= ms; i++) begin
                o = blank((op == T_LW) ? 3 : 5, imm); o.adr = 1; o.memw = (op == T_SW);
                emit(d, o, (i == ms));
            end
            if (op == T_LW) begin
                o = blank(4, imm); o.rs = 1; o.regw = 1; emit(d, o, 1'($urandom_range(0, 1)));
            end
        end else if (op == T_R || op == T_I || op == T_JAL) begin
            if (op == T_JAL) begin
                o = blank(9, imm); o.sa = 1; o.sb = 2; o.pcw = 1;
            end else begin
                o = blank((op == T_R) ? 6 : 7, imm); o.sa = 2; o.sb = (op == T_R) ? 2'd0 : 2'd1;
                o.alu = alu_exp(f3, op == T_R, ins[30]);
            end
            emit(d, o, 1'($urandom_range(0, 1)));
            o = blank(8, imm); o.regw = 1; emit(d, o, 1'($urandom_range(0, 1)));
        end else if (op == T_BR) begin
            o = blank(10, imm); o.sa = 2; o.alu = 3'd1;
            o.pcw = (f3[0] == 1'b0) ? z : !z;
            emit(d, o, 1'($urandom_range(0, 1)));
        end
        if (d == 1) begin b1.Instr = ins; b1.Zero = z; end
        else        begin b2.Instr = ins; b2.Zero = z; end
        while (rq.size() > 0) begin
            if (d == 1) b1.MemReady = rq.pop_front();
            else        b2.MemReady = rq.pop_front();
            @(posedge clk); #1;
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] ins;
        logic [6:0]  ill_ops [6];
        ill_ops = '{7'h7F, 7'h37, 7'h17, 7'h67, 7'h73, 7'h00};
        ins = $urandom;
        case ($urandom_range(0, 6))
            0: ins[6:0] = T_LW;
            1: ins[6:0] = T_SW;
            2: ins[6:0] = T_R;
            3: ins[6:0] = T_I;
            4: ins[6:0] = T_JAL;
            5: begin ins[6:0] = T_BR; ins[14:13] = 2'b00; end
            default: ins[6:0] = ill_ops[$urandom_range(0, 5)];
        endcase
        return ins;
    endfunction

    initial begin
        reset = 1'b1;
        b1.Instr = {25'd0, T_SW}; b1.Zero = 1'b0; b1.MemReady = 1'b1;
        b2.Instr = {25'd0, T_SW}; b2.Zero = 1'b0; b2.MemReady = 1'b1;
        #2;
        chk("rst_state", 32'(b1.State), 32'd0);
        chk("rst_strobes", {27'd0, b1.PCWrite, b1.IRWrite, b1.RegWrite, b1.MemWrite, b1.IllegalInstr}, 32'd0);
        chk("rst_fetch_mux", {26'd0, b1.AdrSrc, b1.ALUSrcA, b1.ALUSrcB, b1.ResultSrc[1]}, 32'b0_00_10_1);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        run(1, 32'h00002083, 1'b0, 0, 0);
        run(1, {7'b0100000, 10'h0A5, 3'b000, 5'd3, T_R}, 1'b0, 0, 0);
        run(1, {7'b0000000, 10'h0A5, 3'b100, 5'd3, T_R}, 1'b0, 0, 0);
        run(1, {7'b0100000, 10'h0A5, 3'b000, 5'd3, T_I}, 1'b0, 0, 0);
        run(1, {17'h00C40, 3'b000, 5'd0, T_BR}, 1'b1, 0, 0);
        run(1, {17'h00C40, 3'b000, 5'd0, T_BR}, 1'b0, 0, 0);
        run(1, {17'h00C40, 3'b001, 5'd0, T_BR}, 1'b0, 0, 0);
        run(1, {17'h00C40, 3'b001, 5'd0, T_BR}, 1'b1, 0, 0);
        run(1, {17'h00C40, 3'b010, 5'd4, T_SW}, 1'b0, 0, 3);
        run(1, {17'h01234, 3'b000, 5'd5, T_I}, 1'b0, 2, 0);
        run(1, {25'h1ABCDEF, 7'h7F}, 1'b0, 0, 0);
        run(1, {20'h00010, 5'd1, T_JAL}, 1'b0, 0, 0);
        for (int n = 0; n < 80; n++)
            run(1, rand_instr(), 1'($urandom_range(0, 1)), $urandom_range(0, 2), $urandom_range(0, 3));

        b1.Instr = {17'h00C40, 3'b010, 5'd4, T_SW}; b1.MemReady = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1 b1.MemReady = 1'b0;
        @(posedge clk); #1;
        chk("pre_rst_state", 32'(b1.State), 32'd5);
        chk("pre_rst_memwrite", 32'(b1.MemWrite), 32'd1);
        b1.MemReady = 1'b1;
        reset = 1'b1;
        #1;
        chk("async_rst_state", 32'(b1.State), 32'd0);
        chk("async_rst_strobes", {28'd0, b1.MemWrite, b1.IRWrite, b1.PCWrite, b1.RegWrite}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        run(2, {17'h00C40, 3'b010, 5'd4, T_SW}, 1'b0, 0, 0);
        run(2, 32'h00002083, 1'b0, 0, 0);
        run(2, {7'b0100000, 10'h0A5, 3'b000, 5'd3, T_R}, 1'b0, 0, 0);
        for (int n = 0; n < 20; n++)
            run(2, rand_instr(), 1'($urandom_range(0, 1)), 0, 0);

        @(negedge clk);
        chk("sb1_drained", 32'(q1.size()), 32'd0);
        chk("sb2_drained", 32'(q2.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
